// File: rtl/hp0_ring_writer.sv
// AXI4-Lite single-beat writer: streams 32-bit words into a circular buffer
// in PS DDR through the HP0 port, one outstanding transaction at a time.
module hp0_ring_writer #(
    parameter int ADDR_W = 32,
    parameter int PTR_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [PTR_W-1:0]  size_words,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [PTR_W-1:0]  wr_idx,
    output logic [15:0]       wrap_cnt,
    output logic              busy,
    output logic              err
);

    // Handshake rule for every channel (s_*, aw, w, b): a beat transfers on a
    // rising edge where valid && ready; a raised valid holds its payload stable
    // and stays high until that edge.

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2
    } state_t;

    state_t state, state_next;

    logic              enable_q;
    logic              load_pend;
    logic [ADDR_W-3:0] base_q;
    logic [PTR_W-1:0]  size_q;
    logic              load_req;
    logic              accept;
    logic              b_done;
    logic              last_word;
    logic [PTR_W:0]    idx_inc;
    logic [PTR_W:0]    ring_len;
    logic [ADDR_W-1:0] next_addr;

    // A rise seen while busy is remembered and applied on return to IDLE.
    assign load_req  = (enable && !enable_q) || load_pend;
    assign s_ready   = (state == IDLE) && enable && !load_req;
    assign accept    = s_valid && s_ready;
    assign b_done    = (state == RESP) && m_bvalid;
    assign m_bready  = (state == RESP);
    assign busy      = (state != IDLE);
    assign m_awprot  = 3'b000;
    assign m_wstrb   = 4'hF;

    // size 0 encodes 2**PTR_W: the extra top bit set with all-zero low bits.
    assign idx_inc   = {1'b0, wr_idx} + 1'b1;
    assign ring_len  = {(size_q == '0), size_q};
    assign last_word = (idx_inc == ring_len);
    assign next_addr = {base_q, 2'b00} + ADDR_W'({wr_idx, 2'b00});

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = ADDR_DATA;
            ADDR_DATA: if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready))
                           state_next = RESP;
            RESP:      if (m_bvalid) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            enable_q  <= 1'b0;
            load_pend <= 1'b0;
            base_q    <= '0;
            size_q    <= '0;
            m_awaddr  <= '0;
            m_awvalid <= 1'b0;
            m_wdata   <= '0;
            m_wvalid  <= 1'b0;
            wr_idx    <= '0;
            wrap_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            enable_q <= enable;
            if (state != IDLE) begin
                if (enable && !enable_q) load_pend <= 1'b1;
            end else begin
                load_pend <= 1'b0;
            end

            if (state == IDLE && load_req) begin
                base_q   <= base_addr[ADDR_W-1:2];
                size_q   <= size_words;
                wr_idx   <= '0;
                wrap_cnt <= '0;
                err      <= 1'b0;
            end

            if (accept) begin
                m_awaddr  <= next_addr;
                m_wdata   <= s_data;
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
            end else begin
                if (m_awvalid && m_awready) m_awvalid <= 1'b0;
                if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
            end

            // The index moves on even for error responses; there is no retry.
            if (b_done) begin
                if (m_bresp != 2'b00) err <= 1'b1;
                if (last_word) begin
                    wr_idx <= '0;
                    if (wrap_cnt != 16'hFFFF) wrap_cnt <= wrap_cnt + 16'd1;
                end else begin
                    wr_idx <= idx_inc[PTR_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_hp0_ring_writer.sv
// Randomized bench for hp0_ring_writer: a ring model predicts each write's
// address/data and the index, wrap and error state after every response.
module tb_hp0_ring_writer;

    localparam int ADDR_W = 32;
    localparam int PTR_W  = 4;

    logic              aclk;
    logic              aresetn;
    logic              enable;
    logic [ADDR_W-1:0] base_addr;
    logic [PTR_W-1:0]  size_words;
    logic              s_valid;
    logic [31:0]       s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] m_awaddr;
    logic [2:0]        m_awprot;
    logic              m_awvalid;
    logic              m_awready;
    logic [31:0]       m_wdata;
    logic [3:0]        m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [PTR_W-1:0]  wr_idx;
    logic [15:0]       wrap_cnt;
    logic              busy;
    logic              err;

    hp0_ring_writer #(.ADDR_W(ADDR_W), .PTR_W(PTR_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .base_addr(base_addr), .size_words(size_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .wr_idx(wr_idx),
        .wrap_cnt(wrap_cnt), .busy(busy), .err(err)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    logic [31:0] m_base;
    int          m_size;
    int          m_idx;
    int          m_wrap;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_load(input logic [31:0] b, input int s);
        m_base = b & 32'hFFFF_FFFC;
        m_size = s;
        m_idx  = 0;
        m_wrap = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_advance(input logic [1:0] resp);
        int len;
        len = (m_size == 0) ? (1 << PTR_W) : m_size;
        if (resp != 2'b00) m_err = 1'b1;
        m_idx = m_idx + 1;
        if (m_idx == len) begin
            m_idx = 0;
            if (m_wrap < 65535) m_wrap = m_wrap + 1;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_idx"},  32'(wr_idx),   32'(m_idx));
        check({tag, "_wrap"}, 32'(wrap_cnt), 32'(m_wrap));
        check({tag, "_err"},  32'(err),      32'(m_err));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_enable(input logic [31:0] b, input logic [PTR_W-1:0] s);
        @(negedge aclk);
        enable = 1'b0;
        base_addr = b;
        size_words = s;
        @(negedge aclk);
        enable = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        model_load(b, int'(s));
    endtask

    task automatic accept_word(input logic [31:0] data, input bit drop_en);
        int waited;
        logic [31:0] ea;
        @(negedge aclk);
        s_valid = 1'b1;
        s_data  = data;
        waited  = 0;
        while (!s_ready && waited < 10) begin
            @(negedge aclk);
            waited++;
        end
        if (!s_ready) begin
            check("accept_timeout", 32'(s_ready), 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
        if (drop_en) enable = 1'b0;
        ea = m_base + 32'(m_idx) * 32'd4;
        exp_q.push_back({ea, data});
    endtask

    task automatic slave_txn(input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] resp, input bit rst_mid);
        logic [63:0] exp;
        bit aw_got, w_got;
        int n;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd0, 32'd1);
            return;
        end
        exp = exp_q.pop_front();
        aw_got = 1'b0;
        w_got  = 1'b0;
        n = 0;
        while (!(aw_got && w_got) && n < 40) begin
            @(negedge aclk);
            if (!aw_got) begin
                check("awvalid_held", 32'(m_awvalid), 32'd1);
                check("awaddr", m_awaddr, exp[63:32]);
                check("awprot", 32'(m_awprot), 32'd0);
            end else begin
                check("awvalid_drop", 32'(m_awvalid), 32'd0);
            end
            if (!w_got) begin
                check("wvalid_held", 32'(m_wvalid), 32'd1);
                check("wdata", m_wdata, exp[31:0]);
                check("wstrb", 32'(m_wstrb), 32'hF);
            end else begin
                check("wvalid_drop", 32'(m_wvalid), 32'd0);
            end
            check("bready_early", 32'(m_bready), 32'd0);
            m_awready = !aw_got && (n >= aw_dly);
            m_wready  = !w_got && (n >= w_dly);
            if (m_awready && m_awvalid) aw_got = 1'b1;
            if (m_wready && m_wvalid)   w_got  = 1'b1;
            n++;
        end
        if (!(aw_got && w_got)) check("aw_w_timeout", 32'(aw_got & w_got), 32'd1);
        @(negedge aclk);
        m_awready = 1'b0;
        m_wready  = 1'b0;
        check("aw_low_resp", 32'(m_awvalid), 32'd0);
        check("w_low_resp",  32'(m_wvalid),  32'd0);
        check("bready_resp", 32'(m_bready),  32'd1);
        if (rst_mid) begin
            aresetn = 1'b0;
            enable  = 1'b0;
            #1;
            check("rst_bready",  32'(m_bready),  32'd0);
            check("rst_busy",    32'(busy),      32'd0);
            check("rst_awvalid", 32'(m_awvalid), 32'd0);
            check("rst_wvalid",  32'(m_wvalid),  32'd0);
            check("rst_awaddr",  m_awaddr,       32'd0);
            check("rst_wdata",   m_wdata,        32'd0);
            check("rst_idx",     32'(wr_idx),    32'd0);
            check("rst_wrap",    32'(wrap_cnt),  32'd0);
            check("rst_err",     32'(err),       32'd0);
            check("rst_sready",  32'(s_ready),   32'd0);
            model_load(32'd0, 0);
            @(negedge aclk);
            aresetn = 1'b1;
            return;
        end
        for (int k = 0; k < b_dly; k++) begin
            @(negedge aclk);
            check("bready_wait", 32'(m_bready), 32'd1);
        end
        m_bvalid = 1'b1;
        m_bresp  = resp;
        @(negedge aclk);
        m_bvalid = 1'b0;
        m_bresp  = 2'b00;
        check("bready_once", 32'(m_bready), 32'd0);
        check("busy_idle",   32'(busy),     32'd0);
        model_advance(resp);
    endtask

    task automatic write_word(input logic [31:0] data, input int aw_dly, input int w_dly,
                              input int b_dly, input logic [1:0] resp);
        accept_word(data, 1'b0);
        slave_txn(aw_dly, w_dly, b_dly, resp, 1'b0);
        check_state("post_write");
    endtask

    task automatic random_write(input logic [1:0] resp);
        write_word($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), resp);
        repeat ($urandom_range(0, 2)) @(negedge aclk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        aresetn = 1'b0;
        enable = 1'b0;
        base_addr = '0;
        size_words = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_awready = 1'b0;
        m_wready = 1'b0;
        m_bresp = 2'b00;
        m_bvalid = 1'b0;
        model_load(32'd0, 0);
        repeat (3) @(negedge aclk);
        check("reset_sready",  32'(s_ready),   32'd0);
        check("reset_awvalid", 32'(m_awvalid), 32'd0);
        check("reset_wvalid",  32'(m_wvalid),  32'd0);
        check("reset_bready",  32'(m_bready),  32'd0);
        check("reset_awaddr",  m_awaddr,       32'd0);
        check("reset_busy",    32'(busy),      32'd0);
        check_state("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        // ring of 4 at 0x1000_0000, six words, all channels ready at once
        set_enable(32'h1000_0000, 4'd4);
        for (int i = 0; i < 6; i++) write_word(32'hD000_0000 + 32'(i), 0, 0, 0, 2'b00);
        check("ring4_idx",  32'(wr_idx),   32'd2);
        check("ring4_wrap", 32'(wrap_cnt), 32'd1);

        // slow AW, immediate W
        write_word(32'hCAFE_0001, 3, 0, 0, 2'b00);
        write_word(32'hCAFE_0002, 0, 2, 1, 2'b00);

        // error response on the second write is sticky; enable toggle clears
        set_enable(32'h2000_0040, 4'd5);
        write_word($urandom, 0, 0, 0, 2'b00);
        write_word($urandom, 1, 1, 0, 2'b10);
        write_word($urandom, 0, 0, 0, 2'b00);
        check("err_sticky", 32'(err), 32'd1);
        set_enable(32'h2000_0040, 4'd5);
        check_state("after_toggle");

        // enable dropped during ADDR_DATA: finish, then stay quiet
        accept_word(32'h0BAD_F00D, 1'b1);
        slave_txn(2, 1, 1, 2'b00, 1'b0);
        check_state("drop_en");
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge aclk);
            check("drop_sready",  32'(s_ready),   32'd0);
            check("drop_awvalid", 32'(m_awvalid), 32'd0);
        end
        s_valid = 1'b0;

        // size 0 means the full 2**PTR_W ring; 17th write lands on base
        set_enable(32'h3000_1003, 4'd0);
        for (int i = 0; i < 17; i++) random_write(2'b00);
        check("full_ring_wrap", 32'(wrap_cnt), 32'd1);

        // single-word ring wraps on every write
        set_enable(32'h0000_0100, 4'd1);
        for (int i = 0; i < 3; i++) random_write(2'b00);
        check("ring1_wrap", 32'(wrap_cnt), 32'd3);

        // config pins are ignored while enabled
        set_enable(32'hFFFF_FFF0, 4'd3);
        base_addr = 32'h1234_5678;
        size_words = 4'd9;
        for (int i = 0; i < 5; i++) random_write(2'b00);

        // randomized rings
        for (int r = 0; r < 3; r++) begin
            set_enable($urandom, 4'($urandom_range(0, 15)));
            for (int i = 0; i < 10; i++)
                random_write(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        // asynchronous reset while waiting for the write response
        set_enable(32'h4000_0000, 4'd2);
        accept_word(32'h5555_AAAA, 1'b0);
        slave_txn(1, 0, 0, 2'b00, 1'b1);
        set_enable(32'h4000_0000, 4'd2);
        write_word(32'h1111_2222, 0, 0, 0, 2'b00);

        if (exp_q.size() != 0) check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d expected finish", n_checks);
        $fatal(1, "timeout");
    end

endmodule
